// File: rtl/div_radix4_pkg.sv
// Shared types and sizing helpers for the radix-4 divider.
package div_pkg;

  // Controller states: IDLE waits for a request, CALC iterates, FIX applies
  // signs, DONE presents the result strobe.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Quotient digit chosen by one radix-4 iteration.
  typedef enum logic [1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_e;

  // Iteration counter width: holds up to WIDTH/2 iterations without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width / 32'sd2) + 32'sd1;
  endfunction

endpackage

// File: rtl/div_radix4_if.sv
// Request/response bundle between a requester and the radix-4 divider.
interface div_radix4_if #(
  parameter int WIDTH = 32
);
  logic             pause;
  logic             flush;
  logic             en;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             vout;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output pause, flush, en, signed_op, dividend, divisor,
    input  ready, vout, q, r
  );

  modport slave (
    input  pause, flush, en, signed_op, dividend, divisor,
    output ready, vout, q, r
  );
endinterface

// File: rtl/div_radix4_lzc.sv
// Leading-one detector: index of the most significant set bit plus a zero flag.
module div_radix4_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         i_val,
  output logic [$clog2(WIDTH)-1:0] o_msb,
  output logic                     o_zero
);
  localparam int IW = $clog2(WIDTH);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    o_msb  = '0;
    o_zero = ~|i_val;
    for (int i = 0; i < WIDTH; i++) begin
      o_msb = i_val[i] ? IW'(i) : o_msb;
    end
  end
endmodule

// File: rtl/div_radix4.sv
// Radix-4 restoring divider (signed/unsigned) with early-out on the dividend's
// leading one, special-case bypass, stall (pause) and abort (flush).
module div_radix4
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  div_radix4_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam int PW = WIDTH + 2;

  // Registered state, operands and outputs
  state_e           r_state;
  logic             r_ready;
  logic             r_vout;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_pr;   // partial remainder
  logic [WIDTH-1:0] r_qd;   // dividend bits shift out of the top, digits in at the bottom
  logic [WIDTH-1:0] r_b;    // |divisor|
  logic [PW-1:0]    r_b3;   // 3*|divisor|
  logic             r_neg_q;
  logic             r_neg_r;

  // Combinational helpers
  state_e           w_state_next;
  logic             w_accept;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_zero;
  logic             w_special;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_a_norm;
  logic [IW-1:0]    w_msb;
  logic [IW-1:0]    w_shamt;
  logic [CW-1:0]    w_n;
  logic [PW-1:0]    w_b3;
  logic [PW+1:0]    w_pr_sh;
  logic [PW+2:0]    w_d1;
  logic [PW+2:0]    w_d2;
  logic [PW+2:0]    w_d3;
  digit_e           w_digit;
  logic [PW-1:0]    w_pr_next;

  div_radix4_lzc #(.WIDTH(WIDTH)) u_lzc (
    .i_val  (w_mag_a),
    .o_msb  (w_msb),
    .o_zero (w_zero)
  );

  // Operand magnitudes, special-case detection and normalisation at accept.
  always_comb begin
    w_accept  = bus.en & r_ready & ~bus.pause;
    w_neg_a   = bus.signed_op & bus.dividend[WIDTH-1];
    w_neg_b   = bus.signed_op & bus.divisor[WIDTH-1];
    w_mag_a   = w_neg_a ? (~bus.dividend + WIDTH'(1'b1)) : bus.dividend;
    w_mag_b   = w_neg_b ? (~bus.divisor + WIDTH'(1'b1)) : bus.divisor;
    w_div0    = ~|bus.divisor;
    w_ovf     = bus.signed_op & (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.divisor);
    w_special = w_div0 | w_ovf | w_zero;
    // Even shift so the top bit pair of the normalised dividend is nonzero.
    w_shamt   = (IW'(WIDTH - 1) - w_msb) & ~IW'(1'b1);
    w_a_norm  = w_mag_a << w_shamt;
    w_n       = CW'(w_msb[IW-1:1]) + CW'(1'b1);
    w_b3      = {2'b00, w_mag_b} + {1'b0, w_mag_b, 1'b0};
  end

  // One radix-4 step: pick the largest multiple of b not exceeding 4*pr+bits.
  always_comb begin
    w_pr_sh   = {r_pr, r_qd[WIDTH-1:WIDTH-2]};
    w_d1      = {1'b0, w_pr_sh} - {5'b00000, r_b};
    w_d2      = {1'b0, w_pr_sh} - {4'b0000, r_b, 1'b0};
    w_d3      = {1'b0, w_pr_sh} - {3'b000, r_b3};
    w_digit   = DIG_0;
    w_pr_next = PW'(w_pr_sh);
    if (!w_d3[PW+2]) begin
      w_digit   = DIG_3;
      w_pr_next = PW'(w_d3);
    end else if (!w_d2[PW+2]) begin
      w_digit   = DIG_2;
      w_pr_next = PW'(w_d2);
    end else if (!w_d1[PW+2]) begin
      w_digit   = DIG_1;
      w_pr_next = PW'(w_d1);
    end else begin
      w_digit   = DIG_0;
      w_pr_next = PW'(w_pr_sh);
    end
  end

  // Next-state logic; flush beats pause, pause beats normal progress.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_special ? ST_DONE : ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(1'b1)) begin
          w_state_next = ST_FIX;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end else if (bus.pause) begin
      w_state_next = r_state;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // State register with registered ready/vout decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_vout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next == ST_IDLE);
      r_vout  <= (w_state_next == ST_DONE);
    end
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_pr    <= '0;
      r_qd    <= '0;
      r_b     <= '0;
      r_b3    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (bus.pause) begin
      r_cnt <= r_cnt;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_b     <= w_mag_b;
            r_b3    <= w_b3;
            r_pr    <= '0;
            r_qd    <= w_a_norm;
            r_cnt   <= w_n;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            if (w_div0) begin
              r_q <= '1;
              r_r <= bus.dividend;
            end else if (w_ovf) begin
              r_q <= bus.dividend;
              r_r <= '0;
            end else if (w_zero) begin
              r_q <= '0;
              r_r <= '0;
            end else begin
              r_q <= r_q;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_CALC: begin
          r_pr  <= w_pr_next;
          r_qd  <= {r_qd[WIDTH-3:0], w_digit};
          r_cnt <= r_cnt - CW'(1'b1);
        end
        ST_FIX: begin
          r_q <= r_neg_q ? (~r_qd + WIDTH'(1'b1)) : r_qd;
          r_r <= WIDTH'(r_neg_r ? (~r_pr + PW'(1'b1)) : r_pr);
        end
        ST_DONE: r_cnt <= r_cnt;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.vout  = r_vout;
  assign bus.q     = r_q;
  assign bus.r     = r_r;

endmodule

// File: tb/tb_div_radix4.sv
// Self-checking bench for div_radix4 (WIDTH=32): behavioural reference model,
// per-cycle compare process, and directed vectors with literal expectations.
module tb_div_radix4;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         sp;
    logic [5:0]   n;
  } ref_t;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_radix4_if #(.WIDTH(W)) bus();

  div_radix4 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic plus the special-case rules.
  function automatic ref_t ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    ref_t   res;
    longint la;
    longint lb;
    longint mag;
    int     m;
    res = '0;
    la  = s ? longint'($signed(a)) : longint'({32'd0, a});
    lb  = s ? longint'($signed(b)) : longint'({32'd0, b});
    mag = (la < 0) ? -la : la;
    if (b == 32'd0) begin
      res.q = 32'hFFFF_FFFF; res.r = a; res.sp = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res.q = a; res.r = 32'd0; res.sp = 1'b1;
    end else if (mag == 0) begin
      res.q = 32'd0; res.r = 32'd0; res.sp = 1'b1;
    end else begin
      res.q = 32'(la / lb);
      res.r = 32'(la % lb);
      m = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) m = i;
      res.n = 6'(m / 2 + 1);
    end
    return res;
  endfunction

  // Model state: busy countdown to the result strobe.
  logic         m_busy;
  logic         m_done;
  int           m_left;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  ref_t         w_ref;

  assign w_ref = ref_div(bus.signed_op, bus.dividend, bus.divisor);

  // Cycle-level expectation of the divider's externally visible behaviour.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
    end else if (bus.flush) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (bus.pause) begin
      m_left <= m_left;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r;
      end
    end else if (bus.en) begin
      if (w_ref.sp) begin
        m_done <= 1'b1; m_q <= w_ref.q; m_r <= w_ref.r;
      end else begin
        m_busy <= 1'b1; m_left <= int'(w_ref.n) + 1; p_q <= w_ref.q; p_r <= w_ref.r;
      end
    end
  end

  // Compare DUT against the model every cycle while out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("ready", W'(bus.ready), W'(!(m_busy || m_done)));
      chk("vout", W'(bus.vout), W'(m_done));
      if (m_done) begin
        chk("q", bus.q, m_q);
        chk("r", bus.r, m_r);
      end
    end
  end

  task automatic do_div(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int elat,
                        input int pfrom, input int pto, input logic junk, input int dhold);
    int lat;
    chk({nm, "_ready_pre"}, W'(bus.ready), 32'd1);
    bus.en = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    lat = 1;
    bus.en = junk; bus.signed_op = ~s; bus.dividend = 32'h5A5A_5A5A; bus.divisor = 32'd3;
    while (!bus.vout && lat < 200) begin
      bus.pause = (lat + 1 >= pfrom) && (lat + 1 <= pto);
      @(negedge clk);
      lat++;
    end
    bus.pause = 1'b0; bus.en = 1'b0;
    chk({nm, "_vout"}, W'(bus.vout), 32'd1);
    chk({nm, "_latency"}, W'(lat), W'(elat));
    chk({nm, "_q"}, bus.q, eq);
    chk({nm, "_r"}, bus.r, er);
    for (int k = 0; k < dhold; k++) begin
      bus.pause = 1'b1;
      @(negedge clk);
      chk({nm, "_vout_hold"}, W'(bus.vout), 32'd1);
    end
    bus.pause = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_post"}, W'(bus.ready), 32'd1);
    chk({nm, "_vout_post"}, W'(bus.vout), 32'd0);
  endtask

  task automatic rnd_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bus.en = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.en = 1'b0;
    lat = 1;
    while (!bus.vout && lat < 80) begin
      bus.pause = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      lat++;
    end
    bus.pause = 1'b0;
    chk("rnd_vout", W'(bus.vout), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ref_t t;
    logic s;
    logic [W-1:0] a, b;
    reset_n = 1'b0;
    bus.pause = 1'b0; bus.flush = 1'b0; bus.en = 1'b0; bus.signed_op = 1'b0;
    bus.dividend = '0; bus.divisor = '0;

    // Pin the reference model with hand-computed values.
    t = ref_div(1'b0, 32'd100, 32'd7);
    chk("model_100_7_q", t.q, 32'd14);
    chk("model_100_7_r", t.r, 32'd2);
    chk("model_100_7_n", W'(t.n), 32'd4);
    t = ref_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("model_m7_2_q", t.q, 32'hFFFF_FFFD);
    chk("model_m7_2_r", t.r, 32'hFFFF_FFFF);
    t = ref_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("model_max_n", W'(t.n), 32'd16);

    // Reset state.
    #12;
    chk("rst_ready", W'(bus.ready), 32'd1);
    chk("rst_vout", W'(bus.vout), 32'd0);
    chk("rst_q", bus.q, 32'd0);
    chk("rst_r", bus.r, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    do_div("u100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          6,  0, -1, 1'b0, 0);
    do_div("sm7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  4,  0, -1, 1'b0, 0);
    do_div("s7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          4,  0, -1, 1'b0, 0);
    do_div("div0",    1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1,  0, -1, 1'b0, 2);
    do_div("ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1,  0, -1, 1'b0, 0);
    do_div("zero",    1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1,  0, -1, 1'b0, 0);
    do_div("max_p",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          23, 5,  9, 1'b1, 0);
    do_div("one",     1'b0, 32'd1,          32'd1,          32'd1,          32'd0,          3,  0, -1, 1'b0, 0);
    do_div("sm100",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  6,  0, -1, 1'b0, 0);
    do_div("u2p31_3", 1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          18, 0, -1, 1'b0, 0);
    do_div("s2p31_2", 1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          18, 0, -1, 1'b0, 0);
    do_div("u5_7",    1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          4,  0, -1, 1'b0, 0);

    // Flush in the fourth cycle of 1000/3: no result, back to idle.
    bus.en = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", W'(bus.ready), 32'd1);
    chk("flush_q_kept", bus.q, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("flush_no_vout", W'(bus.vout), 32'd0);
    end

    // Reset in the third cycle of a second divide.
    bus.en = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", W'(bus.ready), 32'd1);
    chk("midrst_vout", W'(bus.vout), 32'd0);
    chk("midrst_q", bus.q, 32'd0);
    chk("midrst_r", bus.r, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_no_vout", W'(bus.vout), 32'd0);
    end
    do_div("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 4, 0, -1, 1'b0, 0);

    // Random operands with occasional stalls; the compare process checks results.
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: b = b & 32'h0000_000F;
        1: a = a >> $urandom_range(0, 31);
        2: b = b >> $urandom_range(0, 31);
        3: a = a & 32'h0000_00FF;
        4: b = (i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: a = a;
      endcase
      rnd_op(s, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_radix4.md
DIV_RADIX4 -- requirements
Module: div_radix4

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 pause  input  1  stall; freezes all state while high.
REQ-005 flush  input  1  abort in-flight divide; no result produced.
REQ-006 en  input  1  start request; accepted only when ready=1.
REQ-007 signed_op  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-008 dividend  input  WIDTH  numerator, sampled at accept.
REQ-009 divisor  input  WIDTH  denominator, sampled at accept.
REQ-010 ready  output  1  high only in IDLE; block can accept.
REQ-011 vout  output  1  one-cycle result-valid strobe.
REQ-012 q  output  WIDTH  quotient; valid while vout=1; held until next accept.
REQ-013 r  output  WIDTH  remainder; valid while vout=1; held until next accept.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-015 Accept = en & ready & !pause at a rising edge; operands and signed_op SHALL be captured on that edge. en while ready=0 SHALL be ignored.
REQ-016 Operands SHALL be converted to magnitudes (two's-complement negate when signed_op=1 and MSB=1); magnitude of 2^(WIDTH-1) SHALL be represented unsigned in WIDTH bits.
REQ-017 Special cases go IDLE->DONE, vout in cycle after accept: divisor=0 -> q=all ones, r=dividend; signed, dividend=2^(WIDTH-1), divisor=all ones -> q=dividend, r=0; dividend magnitude=0 -> q=0, r=0.
REQ-018 Otherwise, IDLE->CALC; a leading-one detector on |dividend| gives msb index m; magnitude SHALL be left-shifted so its top bit pair is nonzero; CALC SHALL run N=floor(m/2)+1 iterations, one per cycle.
REQ-019 Each iteration: partial remainder (WIDTH+2 bits) compared against 3b, 2b, b (3b precomputed at accept); largest non-negative difference selects digit 3/2/1/0; remainder updated; digit shifted into quotient LSBs.
REQ-020 After iteration N, CALC->FIX (1 cycle): q negated iff signed_op=1 and operand signs differ; r negated iff signed_op=1 and dividend negative.
REQ-021 FIX->DONE; vout=1 for exactly the DONE cycle; DONE->IDLE next unpaused edge, ready=1 in that following cycle.
REQ-022 Normal latency: vout asserted N+2 cycles after accept edge (WIDTH=32, m=31: 18 cycles; m=0: 3 cycles), with pause=0 throughout.
REQ-023 pause=1 SHALL freeze state, counter, datapath and outputs in every state; in DONE, vout SHALL stay high until pause drops and the FSM leaves DONE.
REQ-024 flush=1 SHALL force IDLE on next edge from any state, vout=0; flush has priority over pause and en; q/r keep previous values.
REQ-025 Iteration counter width: $clog2(WIDTH/2)+1; SHALL not wrap within one operation.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, ready=1, vout=0, q=0, r=0, counter=0, operand registers 0, independent of clk.
REQ-027 Reset mid-operation SHALL discard the operation; no vout after reset_n rises.
REQ-028 reset_n deassertion SHALL be synchronised externally; block accepts en on first edge after release.

Structure
REQ-029 Shared package div_pkg SHALL hold: FSM state enum, digit-select encoding, counter-width function of WIDTH.
REQ-030 Leading-one detection SHALL be sub-module div_radix4_lzc (WIDTH-parametrised, combinational, outputs msb index and zero flag).
REQ-031 Design SHALL contain exactly one WIDTH+2-bit partial-remainder register and one 3b adder.

Verification
REQ-032 Unsigned 100 / 7, WIDTH=32 -> q=14, r=2, vout 6 cycles after accept (m=6, N=4).
REQ-033 Signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7 / -2 -> q=0xFFFFFFFD, r=1.
REQ-034 Divisor 0, dividend 0x1234 -> q=0xFFFFFFFF, r=0x1234, vout 1 cycle after accept; signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-035 Unsigned 0xFFFFFFFF / 1 with pause high cycles 5-9 -> q=0xFFFFFFFF, r=0, vout at cycle 23; en during busy ignored.
REQ-036 flush at cycle 4 of 1000/3, then reset_n low at cycle 3 of a second divide -> no vout for either; next 9/3 returns q=3, r=0.
REQ-037 Random 10k signed/unsigned operands, WIDTH in {8,32,64}, checked against reference model, including one-cycle vout and ready return.
